// File: rtl/seg7_capture.sv
// Recovers hex digits from a scanned, multiplexed 7-segment bus: samples the pins,
// debounces each one-hot digit pattern, decodes it and streams each capture out.
module seg7_capture #(
    parameter int NDIG   = 4,
    parameter int STABLE = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        seg_in,
    input  logic [NDIG-1:0]   sel_in,
    input  logic              clr,
    output logic [4*NDIG-1:0] digits,
    output logic [NDIG-1:0]   dig_valid,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_idx,
    output logic [3:0]        out_val,
    output logic              out_err,
    output logic              pat_err,
    output logic              ovf
);
    localparam int          SW    = NDIG + 7;
    localparam logic [7:0]  STAB8 = 8'(STABLE);

    typedef enum logic [1:0] {IDLE, COUNT, HELD} state_t;

    state_t              state_q;
    logic [SW-1:0]       s_q, p_q, s_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [4*NDIG-1:0]   digits_q;
    logic [NDIG-1:0]     dig_valid_q;
    logic                out_valid_q, out_err_q, pat_err_q, ovf_q;
    logic [2:0]          out_idx_q;
    logic [3:0]          out_val_q;

    logic                chg, onehot, cap_go;
    logic [4:0]          dcd;
    logic [2:0]          idx;

    // Returns {legal, hex}; illegal patterns decode to hex 0.
    function automatic logic [4:0] dec(input logic [6:0] seg);
        case (seg)
            7'b1111110: dec = 5'h10;
            7'b0110000: dec = 5'h11;
            7'b1101101: dec = 5'h12;
            7'b1111001: dec = 5'h13;
            7'b0110011: dec = 5'h14;
            7'b1011011: dec = 5'h15;
            7'b1011111: dec = 5'h16;
            7'b1110000: dec = 5'h17;
            7'b1111111: dec = 5'h18;
            7'b1110011: dec = 5'h19;
            7'b1110111: dec = 5'h1A;
            7'b0011111: dec = 5'h1B;
            7'b1001110: dec = 5'h1C;
            7'b0111101: dec = 5'h1D;
            7'b1001111: dec = 5'h1E;
            7'b1000111: dec = 5'h1F;
            default:    dec = 5'h00;
        endcase
    endfunction

    function automatic logic [2:0] enc(input logic [NDIG-1:0] sel);
        enc = '0;
        for (int i = 0; i < NDIG; i++)
            if (sel[i]) enc = 3'(i);
    endfunction

    always_comb begin
        s_d    = {sel_in, seg_in};
        chg    = (s_q != p_q);
        onehot = $onehot(s_q[SW-1:7]);
        dcd    = dec(s_q[6:0]);
        idx    = enc(s_q[SW-1:7]);
        cnt_d  = (s_d != s_q) ? 8'd1 : ((cnt_q >= STAB8) ? STAB8 : cnt_q + 8'd1);
        // One capture per stable episode: HELD only re-arms after the sample changes.
        cap_go = onehot && (state_q != HELD || chg) && (cnt_q == STAB8);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s_q         <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            digits_q    <= '0;
            dig_valid_q <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_val_q   <= '0;
            out_err_q   <= 1'b0;
            pat_err_q   <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            p_q   <= s_q;
            s_q   <= s_d;
            cnt_q <= cnt_d;

            if (!onehot)
                state_q <= IDLE;
            else if (state_q == HELD && !chg)
                state_q <= HELD;
            else if (cnt_q == STAB8)
                state_q <= HELD;
            else
                state_q <= COUNT;

            for (int i = 0; i < NDIG; i++) begin
                if (cap_go && dcd[4] && s_q[7+i]) begin
                    digits_q[4*i +: 4] <= dcd[3:0];
                    dig_valid_q[i]     <= 1'b1;
                end
            end

            if (cap_go && (!out_valid_q || out_ready)) begin
                out_valid_q <= 1'b1;
                out_idx_q   <= idx;
                out_val_q   <= dcd[3:0];
                out_err_q   <= !dcd[4];
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (cap_go && !dcd[4])
                pat_err_q <= 1'b1;
            else if (clr)
                pat_err_q <= 1'b0;

            if (cap_go && out_valid_q && !out_ready)
                ovf_q <= 1'b1;
            else if (clr)
                ovf_q <= 1'b0;
        end
    end

    assign digits    = digits_q;
    assign dig_valid = dig_valid_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_val   = out_val_q;
    assign out_err   = out_err_q;
    assign pat_err   = pat_err_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture (NDIG=4, STABLE=3) with hand-computed expectations.
module tb_seg7_capture;
    logic        clk = 1'b0;
    logic        rst_n, clr, out_ready;
    logic [6:0]  seg_in;
    logic [3:0]  sel_in;
    logic [15:0] digits;
    logic [3:0]  dig_valid;
    logic        out_valid, out_err, pat_err, ovf;
    logic [2:0]  out_idx;
    logic [3:0]  out_val;

    int n_asrt = 0;
    int n_fail = 0;
    int nvalid = 0;

    localparam logic [6:0] P1 = 7'b0110000, P2 = 7'b1101101, P3 = 7'b1111001;
    localparam logic [6:0] P5 = 7'b1011011, P6 = 7'b1011111, P7 = 7'b1110000;
    localparam logic [6:0] P9 = 7'b1110011, PA = 7'b1110111, PB = 7'b0011111;
    localparam logic [6:0] PC = 7'b1001110, PF = 7'b1000111, PBAD = 7'b0000001;

    logic [6:0] sw_pat [4];
    logic [3:0] sw_val [4];

    seg7_capture #(.NDIG(4), .STABLE(3)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .sel_in(sel_in), .clr(clr),
        .digits(digits), .dig_valid(dig_valid), .out_valid(out_valid),
        .out_ready(out_ready), .out_idx(out_idx), .out_val(out_val),
        .out_err(out_err), .pat_err(pat_err), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle; counts cycles with a pending entry.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) nvalid++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic entry(input string tag, input logic [2:0] i, input logic [3:0] v, input logic e);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_idx"},   32'(out_idx),   32'(i));
        chk({tag, "_val"},   32'(out_val),   32'(v));
        chk({tag, "_err"},   32'(out_err),   32'(e));
    endtask

    initial begin
        sw_pat = '{P1, P2, PB, PF};
        sw_val = '{4'h1, 4'h2, 4'hB, 4'hF};

        // Reset with random pins
        rst_n = 1'b0; clr = 1'($urandom); out_ready = 1'($urandom);
        seg_in = 7'($urandom); sel_in = 4'($urandom);
        tick(2);
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_dvalid", 32'(dig_valid), 32'h0);
        chk("rst_ovalid", 32'(out_valid), 32'h0);
        chk("rst_flags", {30'd0, pat_err, ovf}, 32'h0);
        chk("rst_entry", {24'd0, out_idx, out_val, out_err}, 32'h0);
        rst_n = 1'b1; clr = 1'b0; out_ready = 1'b1; sel_in = 4'b0000; seg_in = 7'b0;
        tick(2);

        // Basic capture: visible at E0+3, consumed on the next edge
        sel_in = 4'b0001; seg_in = P3; nvalid = 0;
        tick(3);
        chk("basic_early", 32'(nvalid), 32'd0);
        tick(1);
        entry("basic", 3'd0, 4'h3, 1'b0);
        chk("basic_digit", 32'(digits[3:0]), 32'h3);
        chk("basic_dvalid", 32'(dig_valid), 32'b0001);
        tick(1);
        chk("basic_pulse", 32'(out_valid), 32'd0);
        sel_in = 4'b0000; tick(2);

        // Glitch rejection: alternating 2-cycle runs never reach STABLE
        nvalid = 0; sel_in = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            seg_in = (k % 2 == 0) ? P5 : P6;
            tick(2);
        end
        chk("glitch_none", 32'(nvalid), 32'd0);
        seg_in = P6;
        tick(4);
        entry("glitch", 3'd1, 4'h6, 1'b0);
        tick(2);
        chk("glitch_once", 32'(nvalid), 32'd1);

        // Scan sweep across all four digits
        for (int k = 0; k < 4; k++) begin
            sel_in = 4'(1 << k); seg_in = sw_pat[k];
            tick(4);
            entry($sformatf("sweep%0d", k), 3'(k), sw_val[k], 1'b0);
        end
        sel_in = 4'b0000; tick(1);
        chk("sweep_digits", 32'(digits), 32'hFB21);
        chk("sweep_dvalid", 32'(dig_valid), 32'b1111);

        // Illegal pattern, then blanking, then clear
        sel_in = 4'b0100; seg_in = PBAD;
        tick(4);
        entry("illegal", 3'd2, 4'h0, 1'b1);
        chk("illegal_pat_err", 32'(pat_err), 32'd1);
        chk("illegal_digit", 32'(digits[11:8]), 32'hB);
        nvalid = 0; sel_in = 4'b0000;
        tick(6);
        chk("blank_none", 32'(nvalid), 32'd0);
        chk("blank_pat_err", 32'(pat_err), 32'd1);
        clr = 1'b1; tick(1); clr = 1'b0;
        chk("clr_pat_err", 32'(pat_err), 32'd0);
        chk("clr_digits", 32'(digits), 32'hFB21);

        // Backpressure: second capture dropped
        out_ready = 1'b0;
        sel_in = 4'b0001; seg_in = P7; tick(4);
        entry("bp_first", 3'd0, 4'h7, 1'b0);
        sel_in = 4'b0010; seg_in = P9; tick(2);
        entry("bp_hold", 3'd0, 4'h7, 1'b0);
        tick(2);
        entry("bp_drop", 3'd0, 4'h7, 1'b0);
        chk("bp_ovf", 32'(ovf), 32'd1);
        chk("bp_digits", 32'(digits[7:0]), 32'h97);
        out_ready = 1'b1; clr = 1'b1; sel_in = 4'b0000; tick(1);
        clr = 1'b0; out_ready = 1'b0; tick(1);
        chk("bp_drain", {30'd0, out_valid, ovf}, 32'h0);

        // Collision with out_ready=1: old consumed, new loaded
        sel_in = 4'b0100; seg_in = PA; tick(4);
        entry("col_first", 3'd2, 4'hA, 1'b0);
        sel_in = 4'b1000; seg_in = PC; tick(3);
        out_ready = 1'b1; tick(1);
        entry("col_second", 3'd3, 4'hC, 1'b0);
        chk("col_ovf", 32'(ovf), 32'd0);
        chk("col_digits", 32'(digits), 32'hCA97);
        tick(1);
        chk("col_consumed", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
